// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte sources into a one-byte staging register that feeds a UART transmitter.
// Define UART_TX_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority; round-robin otherwise.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               tx_word,
    output logic                     tx_en,
    input  logic                     tx_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);
    localparam int ID_W = $clog2(N_REQ);

    logic              pending_q, pending_d;
    logic              frame_active_q, frame_active_d;
    logic [7:0]        tx_word_q, tx_word_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic [7:0]        win_byte;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W:0]     cand_sum;
`endif

    // Winner search: fixed priority scans from index 0, round-robin from the pointer with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
        cand_sum  = '0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
            cand = ID_W'(k);
`else
            cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_REQ);
            end
            cand = cand_sum[ID_W-1:0];
`endif
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_byte = data[8*i +: 8];
            end
        end
    end

    // Capture and arbitration are mutually exclusive because one needs pending set and the other clear.
    always_comb begin
        pending_d      = pending_q;
        frame_active_d = frame_active_q;
        tx_word_d      = tx_word_q;
        grant_id_d     = grant_id_q;
        ack_d          = '0;
        frame_cnt_d    = frame_cnt_q;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
        rr_ptr_d       = rr_ptr_q;
`endif
        if (pending_q) begin
            if (tx_ready) begin
                pending_d      = 1'b0;
                frame_active_d = 1'b1;
                frame_cnt_d    = frame_cnt_q + CNT_W'(1);
            end
        end else begin
            if (tx_ready) begin
                frame_active_d = 1'b0;
            end
            if (win_found) begin
                pending_d  = 1'b1;
                tx_word_d  = win_byte;
                grant_id_d = win_idx;
                ack_d      = N_REQ'(1) << win_idx;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
                rr_ptr_d   = (win_idx == ID_W'(N_REQ-1)) ? '0 : win_idx + ID_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q      <= 1'b0;
            frame_active_q <= 1'b0;
            tx_word_q      <= '0;
            grant_id_q     <= '0;
            ack_q          <= '0;
            frame_cnt_q    <= '0;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
            rr_ptr_q       <= '0;
`endif
        end else begin
            pending_q      <= pending_d;
            frame_active_q <= frame_active_d;
            tx_word_q      <= tx_word_d;
            grant_id_q     <= grant_id_d;
            ack_q          <= ack_d;
            frame_cnt_q    <= frame_cnt_d;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
            rr_ptr_q       <= rr_ptr_d;
`endif
        end
    end

    // Enable drops as soon as the transmitter is ready with nothing staged, so no stale byte is sampled.
    assign tx_en     = pending_q | (frame_active_q & ~tx_ready);
    assign busy      = pending_q | frame_active_q;
    assign ack       = ack_q;
    assign tx_word   = tx_word_q;
    assign grant_id  = grant_id_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a slot/frame model.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [8*N-1:0]  data;
    logic [N-1:0]    ack;
    logic [7:0]      tx_word;
    logic            tx_en;
    logic            tx_ready;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic [CW-1:0]   frame_cnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
        .tx_word(tx_word), .tx_en(tx_en), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference model: one staging slot, an in-frame flag, a frame counter and a rotating start index.
    bit         m_valid = 0, m_full = 0, m_frame = 0, was_full = 0;
    logic [7:0] m_byte = '0;
    int         m_owner = 0, m_frames = 0, m_rr = 0, w = 0;
    logic [N-1:0] m_ack = '0;
    bit         took = 0, rst_edge = 0;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        took     = tx_en && tx_ready;
        rst_edge = rst;
        if (rst) begin
            m_valid = 1; m_full = 0; m_frame = 0; m_byte = '0;
            m_owner = 0; m_frames = 0; m_rr = 0; m_ack = '0;
        end else begin
            was_full = m_full;
            m_ack    = '0;
            if (was_full && tx_ready) begin
                m_full   = 0;
                m_frame  = 1;
                m_frames = (m_frames + 1) % (1 << CW);
            end
            if (!was_full && tx_ready) m_frame = 0;
            if (!was_full && req != '0) begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
                w = pick(req, 0);
`else
                w = pick(req, m_rr);
`endif
                m_full   = 1;
                m_byte   = data[8*w +: 8];
                m_owner  = w;
                m_ack[w] = 1'b1;
                m_rr     = (w + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("ack",       32'(ack),       32'(m_ack));
            check_output("tx_word",   32'(tx_word),   32'(m_byte));
            check_output("grant_id",  32'(grant_id),  32'(m_owner));
            check_output("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            check_output("busy",      32'(busy),      32'(m_full | m_frame));
            check_output("tx_en",     32'(tx_en),     32'(m_full | (m_frame & ~tx_ready)));
        end
    end

    // Transmitter model: in auto mode a taken byte keeps tx_ready low for frame_len-1 cycles.
    bit auto_tx = 0;
    int frame_len = 10;
    int tx_cnt = 0;

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        if (rst_edge) begin
            tx_cnt = 0;
            if (auto_tx) tx_ready = 1'b1;
        end else if (auto_tx) begin
            if (took) begin
                tx_cnt   = frame_len - 1;
                tx_ready = 1'b0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                tx_ready = (tx_cnt == 0);
            end else begin
                tx_ready = 1'b1;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int grants[$];
    int want_order[5];
    int takes, acks, low_cnt, last_take, found, t0;

    initial begin
        rst = 1'b1; req = '0; data = '0; tx_ready = 1'b0;
        repeat (2) apply_stimulus();
        rst = 1'b0;
        #1;
        check_output("reset_ack",       32'(ack),       32'h0);
        check_output("reset_tx_word",   32'(tx_word),   32'h0);
        check_output("reset_grant",     32'(grant_id),  32'h0);
        check_output("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        check_output("reset_busy",      32'(busy),      32'h0);
        check_output("reset_tx_en",     32'(tx_en),     32'h0);

        // Single request
        req = 4'b0001; data[7:0] = 8'hA5; tx_ready = 1'b1;
        apply_stimulus();
        req = '0;
        #1;
        check_output("single_ack",     32'(ack),      32'h1);
        check_output("single_tx_word", 32'(tx_word),  32'hA5);
        check_output("single_tx_en",   32'(tx_en),    32'h1);
        check_output("single_grant",   32'(grant_id), 32'h0);
        apply_stimulus();
        check_output("single_frame_cnt", 32'(frame_cnt), 32'h1);

        // Contention, all requesters held
        pulse_reset();
        req = 4'hF; data = 32'h44332211; tx_ready = 1'b1;
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
        want_order = '{0, 0, 0, 0, 0};
`else
        want_order = '{0, 1, 2, 3, 0};
`endif
        grants.delete();
        for (int t = 0; t < 20 && grants.size() < 5; t++) begin
            apply_stimulus();
            if (ack != '0) grants.push_back(int'(grant_id));
        end
        check_output("grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check_output($sformatf("grant_order[%0d]", i), 32'(grants[i]), 32'(want_order[i]));
        end
        req = '0;
        repeat (3) apply_stimulus();

        // Back-to-back frames with a 10-cycle transmitter
        pulse_reset();
        auto_tx = 1; frame_len = 10; tx_ready = 1'b1;
        req = 4'b0001; data[7:0] = 8'h10;
        takes = 0; acks = 0; low_cnt = 0; last_take = -1;
        for (int t = 1; t <= 60; t++) begin
            apply_stimulus();
            if (ack[0]) begin
                acks++;
                data[7:0] = data[7:0] + 8'd1;
            end
            if (took) begin
                if (last_take >= 0) check_output("frame_interval", 32'(t - last_take), 32'd10);
                last_take = t;
                takes++;
            end
            #1;
            if (takes > 0 && !tx_en) low_cnt++;
        end
        check_output("b2b_takes",    32'(takes),   32'd6);
        check_output("b2b_acks",     32'(acks),    32'd7);
        check_output("b2b_tx_en_lo", 32'(low_cnt), 32'd0);

        // Last frame ends with nothing staged
        req = '0;
        found = 0;
        for (int t = 0; t < 40 && found == 0; t++) begin
            apply_stimulus();
            #1;
            if (tx_ready && !m_full && m_frame) found = 1;
        end
        check_output("frame_end_seen", 32'(found), 32'd1);
        check_output("frame_end_tx_en", 32'(tx_en), 32'h0);
        apply_stimulus();
        check_output("frame_end_busy", 32'(busy), 32'h0);

        // Reset while a byte is staged and a frame is running
        req = 4'b0001;
        found = 0;
        for (int t = 0; t < 40 && found == 0; t++) begin
            apply_stimulus();
            if (m_full && m_frame && !tx_ready) found = 1;
        end
        check_output("midframe_seen", 32'(found), 32'd1);
        req = '0;
        pulse_reset();
        #1;
        check_output("abort_tx_en",     32'(tx_en),     32'h0);
        check_output("abort_busy",      32'(busy),      32'h0);
        check_output("abort_frame_cnt", 32'(frame_cnt), 32'h0);
        check_output("abort_ack",       32'(ack),       32'h0);
        req = 4'b0010;
        pulse_reset();
        check_output("rst_vs_arb_ack", 32'(ack), 32'h0);
        req = '0;
        apply_stimulus();

        // Counter wrap after 17 captures
        pulse_reset();
        auto_tx = 0; tx_ready = 1'b1; req = 4'b0001;
        takes = 0;
        for (int t = 0; t < 80 && takes < 17; t++) begin
            apply_stimulus();
            if (took) takes++;
        end
        check_output("wrap_takes",     32'(takes),     32'd17);
        check_output("wrap_frame_cnt", 32'(frame_cnt), 32'h1);
        req = '0;

        // Randomized traffic
        t0 = 0;
        for (int t = 0; t < 3000; t++) begin
            if (t % 200 == 0) begin
                auto_tx   = $urandom_range(0, 1) == 1;
                frame_len = $urandom_range(2, 6);
                tx_cnt    = 0;
                tx_ready  = 1'b1;
            end
            if (!auto_tx) tx_ready = $urandom_range(0, 1) == 1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                if (ack[i] || $urandom_range(0, 4) == 0) data[8*i +: 8] = 8'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            apply_stimulus();
            t0++;
        end
        rst = 1'b0; req = '0;
        repeat (20) apply_stimulus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of frame counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester byte-available level.
REQ-006 data  input  8*N_REQ  byte for requester i on bits [8i+7:8i].
REQ-007 ack  output  N_REQ  one-cycle pulse; requester i byte taken into staging.
REQ-008 tx_word  output  8  byte presented to serial transmitter.
REQ-009 tx_en  output  1  transmitter enable (its connection_status input).
REQ-010 tx_ready  input  1  transmitter ready; 1 = transmitter samples tx_word at next edge if tx_en=1.
REQ-011 grant_id  output  clog2(N_REQ)  index of requester owning tx_word.
REQ-012 busy  output  1  pending | frame_active.
REQ-013 frame_cnt  output  CNT_W  count of bytes handed to transmitter.

Function
REQ-014 SHALL hold a one-byte staging register (tx_word) with flag pending, plus flag frame_active.
REQ-015 Arbitration SHALL occur in any cycle with pending=0 and req!=0; next cycle: pending=1, tx_word=data of winner w, grant_id=w, ack[w]=1 for exactly that one cycle.
REQ-016 ack SHALL be one-hot or zero; no arbitration while pending=1.
REQ-017 Capture SHALL occur at an edge where pending=1 and tx_ready=1: pending cleared, frame_active set, frame_cnt incremented.
REQ-018 tx_en SHALL be combinational: pending | (frame_active & ~tx_ready).
REQ-019 frame_active SHALL clear at an edge where tx_ready=1 and pending=0; tx_en therefore drops the same cycle tx_ready rises with nothing pending (no stale byte sampled).
REQ-020 A byte staged during a frame SHALL be captured on the first tx_ready=1 cycle after that frame (back-to-back, no idle cycle).
REQ-021 Arbitration SHALL be permitted in the cycle after capture, so staging refills during the frame.
REQ-022 Requester dropping req before ack SHALL lose nothing; req is level, data sampled only at arbitration edge.
REQ-023 frame_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Round-robin pointer SHALL update to (w+1) mod N_REQ on each grant; search starts at pointer, ascending with wrap.
REQ-025 tx_ready=1 with pending=0 and frame_active=0 SHALL have no effect (idle).

Reset
REQ-026 rst SHALL clear pending, frame_active, ack, tx_word=0, grant_id=0, frame_cnt=0, rr pointer=0; tx_en=0 and busy=0 the cycle after rst sampled.
REQ-027 rst mid-frame SHALL abort: staged byte discarded, no ack issued, tx_en low so transmitter returns idle.
REQ-028 rst SHALL take priority over simultaneous arbitration or capture.

Configuration
REQ-029 Macro UART_TX_ARBITER_FIXED_PRIO_EN defined: winner SHALL be lowest asserted index; rr pointer unused.
REQ-030 Macro undefined: winner SHALL follow round-robin per REQ-024.

Verification
REQ-031 Single request: req=4'b0001, data[7:0]=8'hA5, tx_ready=1 -> ack[0] next cycle, tx_word=8'hA5, tx_en=1, capture following edge, frame_cnt=1.
REQ-032 Back-to-back: req=4'b0001 held, transmitter model 10-cycle frame -> frames captured every 10 cycles, tx_en never low between, ack[0] once per frame.
REQ-033 Contention RR: req=4'b1111 held -> grant order 0,1,2,3,0; with FIXED_PRIO_EN -> 0,0,0.
REQ-034 Frame end, nothing pending: last frame done, req=0 -> tx_en=0 the cycle tx_ready rises, busy=0 next cycle.
REQ-035 Reset mid-frame: rst pulse with pending=1, frame_active=1 -> tx_en=0, busy=0, frame_cnt=0, no ack.
REQ-036 Wrap: CNT_W=4, 17 captures -> frame_cnt=1.
